// File: rtl/read_ptr_empty_pkg.sv
// Shared FIFO constants used by the read- and write-side pointer logic.
package read_ptr_empty_pkg;

  localparam int unsigned PTR_BITS      = 4;
  localparam int unsigned FIFO_DEPTH    = 1 << (PTR_BITS - 1);
  localparam int unsigned AE_THRESH_DEF = 2;

endpackage

// File: rtl/gray2binary.sv
// Combinational Gray-to-binary converter.
module gray2binary #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      bin_c[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/read_ptr_empty.sv
// FIFO read-side pointer, empty/almost-empty flags, fill level and underflow.
module read_ptr_empty
  import read_ptr_empty_pkg::*;
#(
  parameter int unsigned NUM_BITS  = PTR_BITS,
  parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                r_en,
  input  logic [NUM_BITS-1:0] wr_ptr_gray,
  input  logic                underflow_clr,
  output logic [NUM_BITS-1:0] r_ptr_gray,
  output logic [NUM_BITS-1:0] r_ptr_bin,
  output logic [NUM_BITS-2:0] r_addr,
  output logic                empty,
  output logic                almost_empty,
  output logic [NUM_BITS-1:0] rd_count,
  output logic                underflow
);

  localparam logic [NUM_BITS-1:0] AE_LIMIT = NUM_BITS'(AE_THRESH);

  logic [NUM_BITS-1:0] wq1;
  logic [NUM_BITS-1:0] wq2;
  logic [NUM_BITS-1:0] wbin_sync;
  logic                rd_inc;
  logic [NUM_BITS-1:0] r_ptr_bin_nxt;
  logic [NUM_BITS-1:0] r_ptr_gray_nxt;
  logic [NUM_BITS-1:0] count_nxt;

  // Two-flop synchronizer for the write pointer.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wr_ptr_gray;
      wq2 <= wq1;
    end
  end

  gray2binary #(.W(NUM_BITS)) u_gray2binary (
    .gray  (wq2),
    .bin_c (wbin_sync)
  );

  // Next pointer and flags are computed from the post-read pointer so a read
  // that drains the last entry raises empty on the same edge.
  always_comb begin
    rd_inc         = r_en & ~empty;
    r_ptr_bin_nxt  = r_ptr_bin + NUM_BITS'(rd_inc);
    r_ptr_gray_nxt = r_ptr_bin_nxt ^ (r_ptr_bin_nxt >> 1);
    count_nxt      = wbin_sync - r_ptr_bin_nxt;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_ptr_bin    <= '0;
      r_ptr_gray   <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
    end else begin
      r_ptr_bin    <= r_ptr_bin_nxt;
      r_ptr_gray   <= r_ptr_gray_nxt;
      empty        <= (r_ptr_gray_nxt == wq2);
      almost_empty <= (count_nxt <= AE_LIMIT);
      rd_count     <= count_nxt;
    end
  end

  // Sticky underflow; a new underflow outranks a clear on the same edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      underflow <= 1'b0;
    end else if (r_en && empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  assign r_addr = r_ptr_bin[NUM_BITS-2:0];

endmodule

// File: tb/tb_read_ptr_empty.sv
// Bench for read_ptr_empty: directed scenarios plus randomized traffic checked
// against an occupancy-level model of the read side.
module tb_read_ptr_empty;

  logic       r_clk;
  logic       r_rst;
  logic       r_en;
  logic [3:0] wr_ptr_gray;
  logic       underflow_clr;
  logic [3:0] r_ptr_gray;
  logic [3:0] r_ptr_bin;
  logic [2:0] r_addr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  // Writer position and reference model state (plain integers, mod 16).
  int wr_bin;
  int m_rd;
  int m_s1;
  int m_s2;
  int m_cnt;
  bit m_empty;
  bit m_ae;
  bit m_uf;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  assign wr_ptr_gray = to_gray(wr_bin);

  read_ptr_empty #(.NUM_BITS(4), .AE_THRESH(2)) dut (
    .r_clk         (r_clk),
    .r_rst         (r_rst),
    .r_en          (r_en),
    .wr_ptr_gray   (wr_ptr_gray),
    .underflow_clr (underflow_clr),
    .r_ptr_gray    (r_ptr_gray),
    .r_ptr_bin     (r_ptr_bin),
    .r_addr        (r_addr),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_count      (rd_count),
    .underflow     (underflow)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("r_ptr_bin",    8'(r_ptr_bin),    8'(m_rd));
    chk("r_ptr_gray",   8'(r_ptr_gray),   8'(to_gray(m_rd)));
    chk("r_addr",       8'(r_addr),       8'(m_rd % 8));
    chk("empty",        8'(empty),        8'(m_empty));
    chk("almost_empty", 8'(almost_empty), 8'(m_ae));
    chk("rd_count",     8'(rd_count),     8'(m_cnt));
    chk("underflow",    8'(underflow),    8'(m_uf));
  endtask

  task automatic model_reset();
    m_rd    = 0;
    m_s1    = 0;
    m_s2    = 0;
    m_cnt   = 0;
    m_empty = 1'b1;
    m_ae    = 1'b1;
    m_uf    = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic cycle();
    bit acc;
    @(posedge r_clk);
    if (!r_rst) begin
      model_reset();
    end else begin
      acc = r_en && !m_empty;
      if (r_en && m_empty) m_uf = 1'b1;
      else if (underflow_clr) m_uf = 1'b0;
      m_rd    = (m_rd + int'(acc)) % 16;
      m_cnt   = (m_s2 - m_rd + 16) % 16;
      m_empty = (m_cnt == 0);
      m_ae    = (m_cnt <= 2);
      m_s2    = m_s1;
      m_s1    = wr_bin;
    end
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset assertion, checked before any clock edge.
  task automatic async_reset();
    r_rst  = 1'b0;
    wr_bin = 0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    r_rst = 1'b1;
    r_en = 1'b0;
    underflow_clr = 1'b0;
    wr_bin = 0;
    model_reset();
    #1;
    async_reset();
    chk("rst_empty", 8'(empty), 8'h01);
    chk("rst_count", 8'(rd_count), 8'h00);
    cycles(2);
    r_rst = 1'b1;
    cycles(2);

    // Synchronizer latency, then a single read
    wr_bin = 1;
    cycle();
    chk("lat_e1_empty", 8'(empty), 8'h01);
    cycle();
    chk("lat_e2_empty", 8'(empty), 8'h01);
    cycle();
    chk("lat_e3_empty", 8'(empty), 8'h00);
    chk("lat_e3_count", 8'(rd_count), 8'h01);
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    chk("rd1_bin", 8'(r_ptr_bin), 8'h01);
    chk("rd1_gray", 8'(r_ptr_gray), 8'h01);
    chk("rd1_empty", 8'(empty), 8'h01);

    // Underflow set, hold, clear, set-beats-clear
    r_en = 1'b1;
    cycle();
    chk("uf_set", 8'(underflow), 8'h01);
    chk("uf_ptr_hold", 8'(r_ptr_bin), 8'h01);
    r_en = 1'b0;
    cycle();
    chk("uf_held", 8'(underflow), 8'h01);
    underflow_clr = 1'b1;
    cycle();
    chk("uf_clr", 8'(underflow), 8'h00);
    r_en = 1'b1;
    cycle();
    chk("uf_set_wins", 8'(underflow), 8'h01);
    r_en = 1'b0;
    cycle();
    underflow_clr = 1'b0;

    // Full read-out of 8 entries from pointer 0
    async_reset();
    cycle();
    r_rst = 1'b1;
    wr_bin = 8;
    cycles(3);
    chk("full_count", 8'(rd_count), 8'h08);
    chk("full_ae", 8'(almost_empty), 8'h00);
    r_en = 1'b1;
    cycles(8);
    r_en = 1'b0;
    chk("drain_bin", 8'(r_ptr_bin), 8'h08);
    chk("drain_gray", 8'(r_ptr_gray), 8'h0c);
    chk("drain_empty", 8'(empty), 8'h01);
    chk("drain_addr", 8'(r_addr), 8'h00);

    // Almost-empty boundary and pointer wrap 15 -> 0
    wr_bin = 11;
    cycles(3);
    chk("ae3_count", 8'(rd_count), 8'h03);
    chk("ae3_flag", 8'(almost_empty), 8'h00);
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    chk("ae2_count", 8'(rd_count), 8'h02);
    chk("ae2_flag", 8'(almost_empty), 8'h01);
    wr_bin = 15;
    cycles(3);
    r_en = 1'b1;
    cycles(6);
    r_en = 1'b0;
    chk("wrap15_bin", 8'(r_ptr_bin), 8'h0f);
    chk("wrap15_empty", 8'(empty), 8'h01);
    wr_bin = 0;
    cycles(3);
    chk("wrap_count", 8'(rd_count), 8'h01);
    r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    chk("wrap0_bin", 8'(r_ptr_bin), 8'h00);
    chk("wrap0_gray", 8'(r_ptr_gray), 8'h00);
    chk("wrap0_empty", 8'(empty), 8'h01);

    // Reset in the middle of reading
    wr_bin = 5;
    cycles(3);
    chk("mid_count", 8'(rd_count), 8'h05);
    r_en = 1'b1;
    async_reset();
    chk("mid_rst_count", 8'(rd_count), 8'h00);
    chk("mid_rst_empty", 8'(empty), 8'h01);
    cycles(2);
    r_rst = 1'b1;
    r_en = 1'b0;
    cycle();

    // Randomized traffic; writer never runs more than 8 ahead of the reader
    for (int n = 0; n < 600; n++) begin
      r_en = 1'($urandom_range(0, 1));
      underflow_clr = ($urandom_range(0, 7) == 0);
      if (((wr_bin - m_rd + 16) % 16) < 8 && $urandom_range(0, 1) == 1)
        wr_bin = (wr_bin + 1) % 16;
      if (!r_rst) r_rst = 1'b1;
      else if ($urandom_range(0, 149) == 0) async_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
